// File: rtl/video_timing_gen.sv
// ----------------------------------------------------------------------------
// video_timing_gen
//   Raster timing source feeding video_mixer. Divides clk_vid down to a pixel
//   clock-enable, runs the horizontal/vertical raster counters and produces
//   positive HSync/VSync/HBlank/VBlank pulses. Sync position can be re-centred
//   per frame via hs_shift/vs_shift; the shifts are captured only when the
//   raster moves onto (0,0), so a frame never sees a half-applied shift.
//
// Ports
//   clk_vid      in   video clock
//   rst_n        in   asynchronous active-low reset
//   enable       in   1 = run, 0 = freeze counters and outputs
//   hs_shift     in   signed HSync offset, pixels (-8..+7, + = later)
//   vs_shift     in   signed VSync offset, lines  (-8..+7)
//   ce_pix       out  pixel clock-enable, one clk_vid cycle per pixel
//   hcnt         out  current pixel in line
//   vcnt         out  current line in frame
//   HSync        out  high during horizontal sync
//   VSync        out  high during vertical sync
//   HBlank       out  high when hcnt >= H_ACTIVE
//   VBlank       out  high when vcnt >= V_ACTIVE
//   line_start   out  high with ce_pix when hcnt == 0
//   frame_start  out  high with ce_pix at (0,0)
// ----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int CE_DIV   = 4,
    parameter int H_ACTIVE = 256,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 8,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 27,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk_vid,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [3:0]    hs_shift,
    input  logic [3:0]    vs_shift,
    output logic          ce_pix,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          HSync,
    output logic          VSync,
    output logic          HBlank,
    output logic          VBlank,
    output logic          line_start,
    output logic          frame_start
);

    localparam int DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);

    if (CE_DIV < 1)  begin : g_bad_ce_div  $error("CE_DIV must be >= 1");  end
    if (H_FP < 8)    begin : g_bad_h_fp    $error("H_FP must be >= 8");    end
    if (H_SYNC < 1)  begin : g_bad_h_sync  $error("H_SYNC must be >= 1");  end
    if (H_BP < 8)    begin : g_bad_h_bp    $error("H_BP must be >= 8");    end
    if (V_FP < 8)    begin : g_bad_v_fp    $error("V_FP must be >= 8");    end
    if (V_SYNC < 1)  begin : g_bad_v_sync  $error("V_SYNC must be >= 1");  end
    if (V_BP < 8)    begin : g_bad_v_bp    $error("V_BP must be >= 8");    end

    logic [DW-1:0] div;
    logic [DW-1:0] div_nxt;
    logic [3:0]    hsh;
    logic [3:0]    vsh;
    logic [3:0]    hsh_nxt;
    logic [3:0]    vsh_nxt;
    logic          advance;
    logic          h_last;
    logic          v_last;
    logic          frame_wrap;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic signed [HW+1:0] h_rel;
    logic signed [VW+1:0] v_rel;
    logic          hsync_nxt;
    logic          vsync_nxt;

    always_comb begin
        advance    = enable && (div == DIV_LAST);
        h_last     = (hcnt == HW'(H_TOTAL - 1));
        v_last     = (vcnt == VW'(V_TOTAL - 1));
        frame_wrap = h_last && v_last;

        if (!enable)
            div_nxt = div;
        else if (div == DIV_LAST)
            div_nxt = '0;
        else
            div_nxt = div + 1'b1;

        h_nxt = h_last ? '0 : hcnt + 1'b1;
        if (h_last)
            v_nxt = v_last ? '0 : vcnt + 1'b1;
        else
            v_nxt = vcnt;

        // New shifts take effect on the very edge that enters (0,0), so the
        // whole frame uses one consistent value.
        hsh_nxt = frame_wrap ? hs_shift : hsh;
        vsh_nxt = frame_wrap ? vs_shift : vsh;

        // Offset of the next position from the shifted sync start; sync is
        // active while 0 <= rel < width.
        h_rel = $signed({2'b00, h_nxt})
              - $signed((HW+2)'(H_ACTIVE + H_FP))
              - $signed({{(HW-2){hsh_nxt[3]}}, hsh_nxt});
        v_rel = $signed({2'b00, v_nxt})
              - $signed((VW+2)'(V_ACTIVE + V_FP))
              - $signed({{(VW-2){vsh_nxt[3]}}, vsh_nxt});

        hsync_nxt = !h_rel[HW+1] && (h_rel < $signed((HW+2)'(H_SYNC)));
        vsync_nxt = !v_rel[VW+1] && (v_rel < $signed((VW+2)'(V_SYNC)));
    end

    always_ff @(posedge clk_vid or negedge rst_n) begin
        if (!rst_n) begin
            div         <= '0;
            hcnt        <= HW'(H_TOTAL - 1);
            vcnt        <= VW'(V_TOTAL - 1);
            hsh         <= '0;
            vsh         <= '0;
            ce_pix      <= 1'b0;
            HSync       <= 1'b0;
            VSync       <= 1'b0;
            HBlank      <= 1'b1;
            VBlank      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            ce_pix      <= advance;
            line_start  <= advance && h_last;
            frame_start <= advance && frame_wrap;
            if (advance) begin
                hcnt   <= h_nxt;
                vcnt   <= v_nxt;
                hsh    <= hsh_nxt;
                vsh    <= vsh_nxt;
                HSync  <= hsync_nxt;
                VSync  <= vsync_nxt;
                HBlank <= (h_nxt >= HW'(H_ACTIVE));
                VBlank <= (v_nxt >= VW'(V_ACTIVE));
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    // Main instance: default horizontal timing, short frame (27 lines) so a
    // mid-VSync reset is reachable quickly. VSync lines 16..18.
    logic       clk_vid = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b1;
    logic [3:0] hs_shift = 4'd0;
    logic [3:0] vs_shift = 4'd0;
    logic       ce_pix, HSync, VSync, HBlank, VBlank, line_start, frame_start;
    logic [8:0] hcnt;
    logic [4:0] vcnt;

    // Small instance: CE_DIV=1, 32/8/8/8 horizontal (56), 8/8/3/8 vertical (27).
    logic       rst_s_n  = 1'b0;
    logic       enable_s = 1'b1;
    logic [3:0] hs_s = 4'd0;
    logic [3:0] vs_s = 4'd0;
    logic       ce_s, hsync_s, vsync_s, hblank_s, vblank_s, ls_s, fs_s;
    logic [5:0] hcnt_s;
    logic [4:0] vcnt_s;

    int total = 0;
    int bad   = 0;

    always #5 clk_vid = ~clk_vid;

    video_timing_gen #(
        .CE_DIV(4), .H_ACTIVE(256), .H_FP(16), .H_SYNC(32), .H_BP(48),
        .V_ACTIVE(8), .V_FP(8), .V_SYNC(3), .V_BP(8)
    ) u_dut (
        .clk_vid(clk_vid), .rst_n(rst_n), .enable(enable),
        .hs_shift(hs_shift), .vs_shift(vs_shift),
        .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .line_start(line_start), .frame_start(frame_start)
    );

    video_timing_gen #(
        .CE_DIV(1), .H_ACTIVE(32), .H_FP(8), .H_SYNC(8), .H_BP(8),
        .V_ACTIVE(8), .V_FP(8), .V_SYNC(3), .V_BP(8)
    ) u_small (
        .clk_vid(clk_vid), .rst_n(rst_s_n), .enable(enable_s),
        .hs_shift(hs_s), .vs_shift(vs_s),
        .ce_pix(ce_s), .hcnt(hcnt_s), .vcnt(vcnt_s),
        .HSync(hsync_s), .VSync(vsync_s), .HBlank(hblank_s), .VBlank(vblank_s),
        .line_start(ls_s), .frame_start(fs_s)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Wait for the next ce_pix of the main instance, returning elapsed edges.
    task automatic wait_ce(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk_vid); #1;
            cyc++;
        end while (!ce_pix && cyc < 20);
        if (!ce_pix) chk("ce_timeout", 0, 1);
    endtask

    task automatic rel_check(input string p);
        int early = 0;
        @(negedge clk_vid);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk_vid); #1;
            if (ce_pix) early++;
        end
        chk({p, "_early_ce"}, early, 0);
        @(posedge clk_vid); #1;
        chk({p, "_ce"},     int'(ce_pix), 1);
        chk({p, "_hcnt"},   int'(hcnt), 0);
        chk({p, "_vcnt"},   int'(vcnt), 0);
        chk({p, "_fstart"}, int'(frame_start), 1);
        chk({p, "_lstart"}, int'(line_start), 1);
        chk({p, "_hblank"}, int'(HBlank), 0);
        chk({p, "_vblank"}, int'(VBlank), 0);
        chk({p, "_hsync"},  int'(HSync), 0);
        chk({p, "_vsync"},  int'(VSync), 0);
    endtask

    // Scan one full frame of the small instance starting at (0,0).
    task automatic scan_small(input bit apply, output int hs_first, output int hs_len,
                              output int vs_first, output int vs_last,
                              output int seq_err, output int ce_err, output int wraps);
        int ph, pv, pvs, eh, ev;
        hs_first = -1; hs_len = 0; vs_first = -1; vs_last = -1;
        seq_err = 0; ce_err = 0; wraps = 0;
        ph = 0; pv = 0; pvs = 0;
        for (int k = 0; k < 56 * 27; k++) begin
            if (k > 0) begin
                @(posedge clk_vid); #1;
                eh = (ph == 55) ? 0 : ph + 1;
                ev = (ph == 55) ? ((pv == 26) ? 0 : pv + 1) : pv;
                if (int'(hcnt_s) != eh || int'(vcnt_s) != ev) seq_err++;
                if (ph == 55 && int'(hcnt_s) == 0) wraps++;
                if (int'(vsync_s) != pvs && hcnt_s != 6'd0) seq_err++;
            end
            if (!ce_s) ce_err++;
            if (vcnt_s == 5'd4 && hsync_s) begin
                if (hs_first < 0) hs_first = int'(hcnt_s);
                hs_len++;
            end
            if (vsync_s) begin
                if (vs_first < 0) vs_first = int'(vcnt_s);
                vs_last = int'(vcnt_s);
            end
            if (apply && vcnt_s == 5'd3 && hcnt_s == 6'd0) begin
                hs_s = 4'b1000;  // -8
                vs_s = 4'd7;
            end
            ph = int'(hcnt_s); pv = int'(vcnt_s); pvs = int'(vsync_s);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, per_err, seq_err, hs_first, hs_cnt, hb_first, vb_err, ls_err;
        int st_ce, st_h, n, pvs, early_vs;
        int s_hf, s_hl, s_vf, s_vl, s_seq, s_ce, s_wr;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk_vid);
        #1;
        chk("rst_ce",     int'(ce_pix), 0);
        chk("rst_hcnt",   int'(hcnt), 351);
        chk("rst_vcnt",   int'(vcnt), 26);
        chk("rst_hblank", int'(HBlank), 1);
        chk("rst_vblank", int'(VBlank), 1);
        chk("rst_hsync",  int'(HSync), 0);
        chk("rst_vsync",  int'(VSync), 0);
        chk("rst_fstart", int'(frame_start), 0);

        rel_check("rel1");

        // ---------------- first line ----------------
        per_err = 0; seq_err = 0; hs_first = -1; hs_cnt = 0; hb_first = -1;
        vb_err = 0; ls_err = 0;
        for (int i = 1; i < 352; i++) begin
            wait_ce(cyc);
            if (cyc != 4) per_err++;
            if (int'(hcnt) != i) seq_err++;
            if (HSync) begin
                if (hs_first < 0) hs_first = int'(hcnt);
                hs_cnt++;
            end
            if (HBlank && hb_first < 0) hb_first = int'(hcnt);
            if (VBlank) vb_err++;
            if (line_start || frame_start) ls_err++;
        end
        chk("line_period_err", per_err, 0);
        chk("line_hcnt_err",   seq_err, 0);
        chk("hsync_first",     hs_first, 272);
        chk("hsync_len",       hs_cnt, 32);
        chk("hblank_first",    hb_first, 256);
        chk("line_vblank_err", vb_err, 0);
        chk("line_start_err",  ls_err, 0);
        wait_ce(cyc);
        chk("wrap_period", cyc, 4);
        chk("wrap_hcnt",   int'(hcnt), 0);
        chk("wrap_vcnt",   int'(vcnt), 1);
        chk("wrap_lstart", int'(line_start), 1);
        chk("wrap_fstart", int'(frame_start), 0);

        // ---------------- enable stall at hcnt=100 ----------------
        n = 0;
        while (hcnt != 9'd100 && n < 200) begin wait_ce(cyc); n++; end
        chk("stall_at", int'(hcnt), 100);
        enable = 1'b0;
        st_ce = 0; st_h = 0;
        repeat (10) begin
            @(posedge clk_vid); #1;
            if (ce_pix) st_ce++;
            if (hcnt != 9'd100) st_h++;
        end
        chk("stall_ce",   st_ce, 0);
        chk("stall_hold", st_h, 0);
        enable = 1'b1;
        wait_ce(cyc);
        chk("resume_hcnt",  int'(hcnt), 101);
        chk("resume_delay", cyc, 4);
        n = 0;
        do begin wait_ce(cyc); n++; end while (hcnt != 9'd0 && n < 400);
        chk("resume_rest_of_line", n, 251);
        chk("resume_next_vcnt", int'(vcnt), 2);

        // ---------------- VSync entry and reset mid-VSync ----------------
        n = 0; pvs = 0; early_vs = 0;
        while (vcnt != 5'd16 && n < 7000) begin
            pvs = int'(VSync);
            if (VSync) early_vs++;
            wait_ce(cyc); n++;
        end
        chk("vs_prev",   pvs, 0);
        chk("vs_early",  early_vs, 0);
        chk("vs_rise",   int'(VSync), 1);
        chk("vs_rise_h", int'(hcnt), 0);
        n = 0;
        while (!(vcnt == 5'd17 && hcnt == 9'd10) && n < 1000) begin wait_ce(cyc); n++; end
        chk("vs_mid", int'(VSync), 1);
        rst_n = 1'b0;
        #1;
        chk("rst2_vsync",  int'(VSync), 0);
        chk("rst2_ce",     int'(ce_pix), 0);
        chk("rst2_hcnt",   int'(hcnt), 351);
        chk("rst2_vcnt",   int'(vcnt), 26);
        chk("rst2_hblank", int'(HBlank), 1);
        @(posedge clk_vid);
        rel_check("rel2");

        // ---------------- CE_DIV=1 instance, shift latching ----------------
        @(negedge clk_vid);
        rst_s_n = 1'b1;
        @(posedge clk_vid); #1;
        chk("s_first_fs",   int'(fs_s), 1);
        chk("s_first_hcnt", int'(hcnt_s), 0);
        chk("s_first_vcnt", int'(vcnt_s), 0);
        scan_small(1'b1, s_hf, s_hl, s_vf, s_vl, s_seq, s_ce, s_wr);
        chk("s0_hs_first", s_hf, 40);
        chk("s0_hs_len",   s_hl, 8);
        chk("s0_vs_first", s_vf, 16);
        chk("s0_vs_last",  s_vl, 18);
        chk("s0_seq_err",  s_seq, 0);
        chk("s0_ce_err",   s_ce, 0);
        chk("s0_wraps",    s_wr, 26);
        @(posedge clk_vid); #1;
        chk("s1_fs",   int'(fs_s), 1);
        chk("s1_hcnt", int'(hcnt_s), 0);
        chk("s1_vcnt", int'(vcnt_s), 0);
        scan_small(1'b0, s_hf, s_hl, s_vf, s_vl, s_seq, s_ce, s_wr);
        chk("s1_hs_first", s_hf, 32);
        chk("s1_hs_len",   s_hl, 8);
        chk("s1_vs_first", s_vf, 23);
        chk("s1_vs_last",  s_vl, 25);
        chk("s1_seq_err",  s_seq, 0);
        chk("s1_ce_err",   s_ce, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
